dcache_ctrl: RTL and testbench

- Data-cache controller sitting directly upstream of the 2-way, 16-set dcache SRAM and between the CPU MEM stage and data memory.
- Decodes CPU addresses, drives SRAM lookups and writes, merges word stores into 256-bit lines, and stalls the CPU on a miss.
- Runs dirty-victim write-back and line refill over a level/ack memory handshake.

---
 rtl/dcache_ctrl_if.sv | 60 ++++++
 rtl/dcache_ctrl.sv | 154 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_if.sv
// ---------------------------------------------------------------------------
// dcache_ctrl_if
//   Bundles every bus the data-cache controller talks to:
//     cpu_*   : MEM-stage request (address, store data, read/write strobes),
//               load data and pipeline stall back to the CPU.
//     sram_*  : lookup/write port of the 2-way, 16-set tag+data SRAM. The
//               SRAM returns the hit way on a hit, the LRU victim on a miss.
//     mem_*   : line-wide level/ack memory port. mem_enable_o is held high
//               until mem_ack_i pulses for one cycle.
//     dbg_state_o : current controller FSM state, for observation only.
//   Modports:
//     slave  : the controller (dcache_ctrl)
//     master : the environment around it (CPU, SRAM, memory)
// ---------------------------------------------------------------------------
interface dcache_ctrl_if;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;

    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o;
    logic [255:0] sram_data_o;
    logic         sram_enable_o;
    logic         sram_write_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_hit_i;

    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    logic [2:0]   dbg_state_o;

    modport slave (
        input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        output cpu_data_o, cpu_stall_o,
        output sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
        input  sram_tag_i, sram_data_i, sram_hit_i,
        output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
        input  mem_data_i, mem_ack_i,
        output dbg_state_o
    );

    modport master (
        output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        input  cpu_data_o, cpu_stall_o,
        input  sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
        output sram_tag_i, sram_data_i, sram_hit_i,
        input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
        output mem_data_i, mem_ack_i,
        input  dbg_state_o
    );
endinterface

// File: rtl/dcache_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_ctrl
//   Data-cache controller between the CPU MEM stage, the 2-way/16-set dcache
//   SRAM and line-wide data memory.
//     - Hits complete in the request cycle: loads return the selected word
//       combinationally, stores merge the word into the line and write it
//       back to the SRAM with the dirty bit set.
//     - Misses stall the CPU, optionally write back a dirty victim, refill
//       the line and then let the held request re-look-up and hit.
//   Ports:
//     clk_i : clock
//     rst_i : synchronous, active-high reset
//     bus   : dcache_ctrl_if.slave (CPU, SRAM and memory buses, debug state)
//   Handshake: the memory request is level based. mem_enable_o/mem_write_o/
//   mem_addr_o/mem_data_o are registered and held stable until the cycle in
//   which mem_ack_i is high; that cycle completes the transfer.
// ---------------------------------------------------------------------------
module dcache_ctrl (
    input  logic          clk_i,
    input  logic          rst_i,
    dcache_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MISS      = 3'd1,
        S_WRITEBACK = 3'd2,
        S_REFILL    = 3'd3,
        S_REFILL_OK = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic          mem_enable_q, mem_enable_d;
    logic          mem_write_q, mem_write_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [255:0]  mem_data_q, mem_data_d;

    logic [22:0]   req_tag;
    logic [3:0]    req_idx;
    logic [2:0]    req_word;
    logic          req;
    logic          is_write;
    logic [255:0]  merged_line;
    logic          sram_write;

    // The stalled CPU holds its request stable, so the live address is used
    // throughout a miss rather than a latched copy.
    assign req_tag  = bus.cpu_addr_i[31:9];
    assign req_idx  = bus.cpu_addr_i[8:5];
    assign req_word = bus.cpu_addr_i[4:2];
    assign req      = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
    // Read and write together is a write.
    assign is_write = bus.cpu_MemWrite_i;

    always_comb begin
        merged_line = bus.sram_data_i;
        merged_line[{req_word, 5'b0} +: 32] = bus.cpu_data_i;
    end

    assign bus.cpu_data_o    = bus.sram_data_i[{req_word, 5'b0} +: 32];
    assign bus.sram_addr_o   = req_idx;
    assign bus.sram_enable_o = req | (state_q != S_IDLE);
    assign bus.mem_enable_o  = mem_enable_q;
    assign bus.mem_write_o   = mem_write_q;
    assign bus.mem_addr_o    = mem_addr_q;
    assign bus.mem_data_o    = mem_data_q;
    assign bus.dbg_state_o   = state_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        mem_enable_d     = mem_enable_q;
        mem_write_d      = mem_write_q;
        mem_addr_d       = mem_addr_q;
        mem_data_d       = mem_data_q;
        sram_write       = 1'b0;
        bus.sram_data_o  = merged_line;
        bus.sram_tag_o   = {1'b1, 1'b0, req_tag};
        bus.cpu_stall_o  = 1'b1;

        case (state_q)
            S_IDLE: begin
                bus.cpu_stall_o = req & ~bus.sram_hit_i;
                if (req && bus.sram_hit_i && is_write) begin
                    sram_write     = 1'b1;
                    bus.sram_tag_o = {1'b1, 1'b1, req_tag};
                end
                if (req && !bus.sram_hit_i) begin
                    state_d = S_MISS;
                end
            end
            S_MISS: begin
                // The SRAM presents the LRU victim now. An invalid victim is
                // clean regardless of its dirty bit.
                if (bus.sram_tag_i[24] && bus.sram_tag_i[23]) begin
                    mem_addr_d   = {bus.sram_tag_i[22:0], req_idx, 5'b0};
                    mem_data_d   = bus.sram_data_i;
                    mem_write_d  = 1'b1;
                    mem_enable_d = 1'b1;
                    state_d      = S_WRITEBACK;
                end else begin
                    mem_addr_d   = {req_tag, req_idx, 5'b0};
                    mem_write_d  = 1'b0;
                    mem_enable_d = 1'b1;
                    state_d      = S_REFILL;
                end
            end
            S_WRITEBACK: begin
                // Enable stays high: the refill request follows back-to-back.
                if (bus.mem_ack_i) begin
                    mem_addr_d  = {req_tag, req_idx, 5'b0};
                    mem_write_d = 1'b0;
                    state_d     = S_REFILL;
                end
            end
            S_REFILL: begin
                if (bus.mem_ack_i) begin
                    mem_enable_d    = 1'b0;
                    sram_write      = 1'b1;
                    bus.sram_data_o = bus.mem_data_i;
                    bus.sram_tag_o  = {1'b1, 1'b0, req_tag};
                    state_d         = S_REFILL_OK;
                end
            end
            S_REFILL_OK: begin
                // One quiet cycle so the refilled line is visible before the
                // held request re-looks-up in IDLE.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A reset arriving mid-refill discards the line: no SRAM write that cycle.
    assign bus.sram_write_o = sram_write & ~rst_i;

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam int FREE = -2;
    localparam int HIT  = -1;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    dcache_ctrl_if bus();
    dcache_ctrl dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [32:0] mem_q[$];

    // ---------------- SRAM model: 2 ways x 16 sets, LRU victim ----------------
    logic [24:0]  tag_m  [2][16] = '{default: '0};
    logic [255:0] data_m [2][16] = '{default: '0};
    logic         lru_m  [16]    = '{default: 1'b0};
    logic         hit0, hit1, hway;
    logic [3:0]   sset;
    logic [22:0]  stag;

    always_comb begin
        sset = bus.sram_addr_o;
        stag = bus.cpu_addr_i[31:9];
        hit0 = tag_m[0][sset][24] && (tag_m[0][sset][22:0] == stag);
        hit1 = tag_m[1][sset][24] && (tag_m[1][sset][22:0] == stag);
        hway = hit0 ? 1'b0 : (hit1 ? 1'b1 : lru_m[sset]);
        bus.sram_hit_i  = hit0 | hit1;
        bus.sram_tag_i  = tag_m[hway][sset];
        bus.sram_data_i = data_m[hway][sset];
    end

    always @(posedge clk_i) begin
        if (bus.sram_enable_o && bus.sram_write_o) begin
            tag_m[hway][sset]  <= bus.sram_tag_o;
            data_m[hway][sset] <= bus.sram_data_o;
        end
        if (bus.sram_enable_o && (bus.sram_hit_i || bus.sram_write_o))
            lru_m[sset] <= ~hway;
    end

    // ---------------- architectural and backing memory ----------------
    logic [31:0]  arch_m [logic [31:0]];
    logic [255:0] back_m [logic [31:0]];

    function automatic logic [31:0] pat(input logic [31:0] a);
        if (a == 32'h0000_0420) return 32'hDEAD_BEEF;
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] arch_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (arch_m.exists(wa)) return arch_m[wa];
        return pat(wa);
    endfunction

    function automatic logic [255:0] arch_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = arch_word({la[31:5], 5'b0} + 32'(w * 4));
        return l;
    endfunction

    function automatic logic [255:0] back_line(input logic [31:0] la);
        logic [255:0] l;
        if (back_m.exists(la)) return back_m[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = pat(la + 32'(w * 4));
        return l;
    endfunction

    // One CPU access held until the stall drops; acts as the memory responder.
    // exp_after: HIT, FREE (no latency/request checks) or stalled cycles after
    // the first miss cycle.
    task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic rd, input logic wr, input int n_ack,
                          input int exp_after, input string name);
        int stalls, cnt, cyc;
        bit seen, done;
        logic [255:0] line;
        @(negedge clk_i);
        bus.cpu_addr_i     = addr;
        bus.cpu_data_i     = wdata;
        bus.cpu_MemRead_i  = rd;
        bus.cpu_MemWrite_i = wr;
        if (!wr) exp_q.push_back(arch_word(addr));
        stalls = 0; cnt = 0; seen = 0; done = 0;
        for (cyc = 0; cyc < 300 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk_i);
            bus.mem_ack_i  = 1'b0;
            bus.mem_data_i = '0;
            #1;
            if (!bus.cpu_stall_o) begin
                done = 1;
                if (wr) begin
                    line = arch_line(addr);
                    line[{addr[4:2], 5'b0} +: 32] = wdata;
                    checks++;
                    if (bus.sram_write_o !== 1'b1 || bus.sram_tag_o !== {2'b11, addr[31:9]} ||
                        bus.sram_data_o !== line) begin
                        errors++;
                        $display("FAIL %s store: write=%b tag=%h data=%h, want write=1 tag=%h data=%h",
                                 name, bus.sram_write_o, bus.sram_tag_o, bus.sram_data_o,
                                 {2'b11, addr[31:9]}, line);
                    end
                    arch_m[{addr[31:2], 2'b00}] = wdata;
                end else begin
                    checks++;
                    if (exp_q.size() == 0 || bus.cpu_data_o !== exp_q[0]) begin
                        errors++;
                        $display("FAIL %s load: got %h want %h", name, bus.cpu_data_o,
                                 exp_q.size() ? exp_q[0] : 32'hx);
                    end
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
            end else begin
                stalls++;
                if (bus.mem_enable_o) begin
                    if (!seen) begin
                        seen = 1;
                        cnt  = n_ack;
                        if (exp_after != FREE) begin
                            checks++;
                            if (mem_q.size() == 0 || {bus.mem_write_o, bus.mem_addr_o} !== mem_q[0]) begin
                                errors++;
                                $display("FAIL %s mem_req: got w=%b a=%h want %h", name,
                                         bus.mem_write_o, bus.mem_addr_o,
                                         mem_q.size() ? mem_q[0] : 33'hx);
                            end
                            if (mem_q.size() != 0) void'(mem_q.pop_front());
                        end
                    end
                    if (cnt == 0) begin
                        bus.mem_ack_i = 1'b1;
                        seen = 0;
                        if (bus.mem_write_o) begin
                            checks++;
                            if (bus.mem_data_o !== arch_line(bus.mem_addr_o)) begin
                                errors++;
                                $display("FAIL %s wb_data: got %h want %h", name,
                                         bus.mem_data_o, arch_line(bus.mem_addr_o));
                            end
                            back_m[bus.mem_addr_o] = bus.mem_data_o;
                        end else begin
                            bus.mem_data_i = back_line(bus.mem_addr_o);
                        end
                    end else begin
                        cnt--;
                    end
                end
            end
        end
        bus.mem_ack_i = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: stall still %b after %0d cycles", name, bus.cpu_stall_o, cyc);
        end
        if (exp_after != FREE) begin
            checks++;
            if (stalls !== ((exp_after == HIT) ? 0 : exp_after + 1)) begin
                errors++;
                $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls,
                         (exp_after == HIT) ? 0 : exp_after + 1);
            end
            checks++;
            if (mem_q.size() != 0) begin
                errors++;
                $display("FAIL %s mem_req_missing: %0d expected requests not seen", name, mem_q.size());
                mem_q.delete();
            end
        end
    endtask

    task automatic idle_inputs();
        bus.cpu_MemRead_i  = 1'b0;
        bus.cpu_MemWrite_i = 1'b0;
        bus.mem_ack_i      = 1'b0;
        bus.mem_data_i     = '0;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (bus.dbg_state_o !== ST_IDLE || bus.mem_enable_o !== 1'b0 || bus.cpu_stall_o !== 1'b0 ||
            bus.sram_write_o !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: state=%0d en=%b stall=%b swr=%b, want 0 0 0 0", name,
                     bus.dbg_state_o, bus.mem_enable_o, bus.cpu_stall_o, bus.sram_write_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        bus.cpu_addr_i = '0;
        bus.cpu_data_i = '0;
        idle_inputs();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        checks++;
        if (bus.mem_enable_o !== 1'b0 || bus.mem_write_o !== 1'b0 || bus.mem_addr_o !== 32'h0 ||
            bus.mem_data_o !== 256'h0 || bus.sram_enable_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem: en=%b wr=%b addr=%h data_nz=%b senable=%b, want all 0",
                     bus.mem_enable_o, bus.mem_write_o, bus.mem_addr_o, |bus.mem_data_o, bus.sram_enable_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        check_idle("reset");
    endtask

    task automatic test_read_miss();
        mem_q.push_back({1'b0, 32'h0000_0420});
        access(32'h0000_0420, 32'h0, 1'b1, 1'b0, 3, 6, "read_miss");
    endtask

    task automatic test_store_hit();
        access(32'h0000_0424, 32'h1234_5678, 1'b0, 1'b1, 1, HIT, "store_hit");
        access(32'h0000_0424, 32'h0, 1'b1, 1'b0, 1, HIT, "load_after_store");
    endtask

    task automatic test_dirty_evict();
        mem_q.push_back({1'b0, 32'h0000_1020});
        access(32'h0000_1020, 32'hCAFE_0001, 1'b0, 1'b1, 2, 5, "store_miss_clean");
        mem_q.push_back({1'b1, 32'h0000_0420});
        mem_q.push_back({1'b0, 32'h0000_2020});
        access(32'h0000_2028, 32'h0, 1'b1, 1'b0, 2, 8, "dirty_evict");
        mem_q.push_back({1'b1, 32'h0000_1020});
        mem_q.push_back({1'b0, 32'h0000_0420});
        access(32'h0000_0424, 32'h0, 1'b1, 1'b0, 1, 6, "refetch_written_back");
    endtask

    task automatic test_reset_mid_wb();
        bit found;
        access(32'h0000_2020, 32'h0BAD_0001, 1'b0, 1'b1, 1, HIT, "dirty_way0");
        access(32'h0000_0420, 32'h0BAD_0002, 1'b0, 1'b1, 1, HIT, "dirty_way1");
        @(negedge clk_i);
        bus.cpu_addr_i    = 32'h0000_3020;
        bus.cpu_MemRead_i = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_i);
            #1;
            if (bus.mem_enable_o && bus.mem_write_o) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_mid_wb reach_wb: no write-back request seen, en=%b wr=%b",
                     bus.mem_enable_o, bus.mem_write_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        idle_inputs();
        @(negedge clk_i);
        #1;
        check_idle("reset_mid_wb");
        rst_i = 1'b0;
        access(32'h0000_2020, 32'h0, 1'b1, 1'b0, 1, HIT, "after_reset_hit");
    endtask

    task automatic test_stray_ack();
        @(negedge clk_i);
        idle_inputs();
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = '1;
        #1;
        checks++;
        if (bus.sram_write_o !== 1'b0 || bus.sram_enable_o !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack sram: write=%b enable=%b want 0 0", bus.sram_write_o, bus.sram_enable_o);
        end
        @(negedge clk_i);
        bus.mem_ack_i = 1'b0;
        #1;
        check_idle("stray_ack");
    endtask

    task automatic test_read_and_write();
        access(32'h0000_2024, 32'h55AA_55AA, 1'b1, 1'b1, 1, HIT, "rd_wr_both");
        access(32'h0000_2024, 32'h0, 1'b1, 1'b0, 1, HIT, "rd_wr_readback");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic        w;
        for (int i = 0; i < 24; i++) begin
            a = {23'(32'h40 + $urandom_range(0, 2)), 4'd3, 3'($urandom_range(0, 7)), 2'b00};
            w = 1'($urandom_range(0, 1));
            access(a, $urandom, ~w, w, $urandom_range(1, 4), FREE, "b2b");
        end
        @(negedge clk_i);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_store_hit();
        test_dirty_evict();
        test_reset_mid_wb();
        test_stray_ack();
        test_read_and_write();
        test_back_to_back();
        repeat (2) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
